// File: rtl/line_window_gen.sv
// Line-buffer controller that cascades raster rows through two external 1-cycle RAMs
// and emits a registered 3x3 window for every interior pixel of the frame.
module line_window_gen #(
  parameter int IMG_WIDTH  = 1600,
  parameter int IMG_HEIGHT = 1200,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_pixel,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic [ADDR_W-1:0]   lb0_addr,
  output logic                lb0_we,
  output logic [DATA_W-1:0]   lb0_din,
  input  logic [DATA_W-1:0]   lb0_dout,
  output logic [ADDR_W-1:0]   lb1_addr,
  output logic                lb1_we,
  output logic [DATA_W-1:0]   lb1_din,
  input  logic [DATA_W-1:0]   lb1_dout,
  output logic                win_valid,
  output logic [9*DATA_W-1:0] win_data,
  output logic                frame_done
);

  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  // Raster position of the pixel presented this cycle
  logic [ADDR_W-1:0] r_col;
  logic [ROW_W-1:0]  r_row;
  logic              w_sof;
  logic [ADDR_W-1:0] w_cur_col;
  logic [ROW_W-1:0]  w_cur_row;
  logic              w_last_col;
  logic              w_last_row;

  assign w_sof      = in_sof & in_valid;
  assign w_cur_col  = w_sof ? '0 : r_col;
  assign w_cur_row  = w_sof ? '0 : r_row;
  assign w_last_col = (w_cur_col == LAST_COL);
  assign w_last_row = (w_cur_row == LAST_ROW);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_cur_row + ROW_W'(1);
      end else begin
        r_col <= w_cur_col + ADDR_W'(1);
        r_row <= w_cur_row;
      end
    end
  end

  // Stage 0: the pixel is written to lb0 while the row above is read out
  assign lb0_addr = w_cur_col;
  assign lb0_din  = in_pixel;
  assign lb0_we   = in_valid & rst_n;

  // Stage 1
  logic [DATA_W-1:0] r_pixel_d1;
  logic [ADDR_W-1:0] r_col_d1;
  logic [ROW_W-1:0]  r_row_d1;
  logic              r_valid_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_d1 <= '0;
      r_col_d1   <= '0;
      r_row_d1   <= '0;
      r_valid_d1 <= 1'b0;
    end else begin
      r_valid_d1 <= in_valid;
      if (in_valid) begin
        r_pixel_d1 <= in_pixel;
        r_col_d1   <= w_cur_col;
        r_row_d1   <= w_cur_row;
      end
    end
  end

  // lb0 read data (row-1) moves into lb1 while lb1 returns row-2
  assign lb1_addr = r_col_d1;
  assign lb1_din  = lb0_dout;
  assign lb1_we   = r_valid_d1;

  // Stage 2: RAM outputs are only meaningful the cycle right after their write
  logic [DATA_W-1:0] r_bot;
  logic [DATA_W-1:0] r_mid;
  logic [ADDR_W-1:0] r_col_d2;
  logic [ROW_W-1:0]  r_row_d2;
  logic              r_last_d2;
  logic              r_valid_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bot      <= '0;
      r_mid      <= '0;
      r_col_d2   <= '0;
      r_row_d2   <= '0;
      r_last_d2  <= 1'b0;
      r_valid_d2 <= 1'b0;
    end else begin
      r_valid_d2 <= r_valid_d1;
      if (r_valid_d1) begin
        r_bot     <= r_pixel_d1;
        r_mid     <= lb0_dout;
        r_col_d2  <= r_col_d1;
        r_row_d2  <= r_row_d1;
        r_last_d2 <= (r_col_d1 == LAST_COL) && (r_row_d1 == LAST_ROW);
      end
    end
  end

  // Stage 3: shift window columns left, new column enters at j=2
  logic [DATA_W-1:0] r_top_col [3];
  logic [DATA_W-1:0] r_mid_col [3];
  logic [DATA_W-1:0] r_bot_col [3];
  logic              r_win_valid;
  logic              r_frame_done;
  logic              w_win_ok;

  // Rows 0-1 and columns 0-1 hold stale RAM data or previous-line pixels
  assign w_win_ok = r_valid_d2 && (r_row_d2 >= ROW_W'(2)) && (r_col_d2 >= ADDR_W'(2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) begin
        r_top_col[j] <= '0;
        r_mid_col[j] <= '0;
        r_bot_col[j] <= '0;
      end
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_win_valid  <= w_win_ok;
      r_frame_done <= w_win_ok & r_last_d2;
      if (r_valid_d2) begin
        for (int j = 0; j < 2; j++) begin
          r_top_col[j] <= r_top_col[j+1];
          r_mid_col[j] <= r_mid_col[j+1];
          r_bot_col[j] <= r_bot_col[j+1];
        end
        r_top_col[2] <= lb1_dout;
        r_mid_col[2] <= r_mid;
        r_bot_col[2] <= r_bot;
      end
    end
  end

  // NOTE: combinational blocks assign a default first so no path leaves a bit
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    win_data = '0;
    for (int j = 0; j < 3; j++) begin
      win_data[DATA_W*(0+j) +: DATA_W] = r_top_col[j];
      win_data[DATA_W*(3+j) +: DATA_W] = r_mid_col[j];
      win_data[DATA_W*(6+j) +: DATA_W] = r_bot_col[j];
    end
  end

  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench: a 4x4 instance for timing/boundary cases and a 1600-wide
// instance checked against a 3x3 reference over a random 1600x4 image.
module tb_line_window_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Small instance (4x4)
  logic [7:0]  s_pix;
  logic        s_valid, s_sof;
  logic [10:0] s_lb0_addr, s_lb1_addr;
  logic        s_lb0_we, s_lb1_we;
  logic [7:0]  s_lb0_din, s_lb1_din, s_lb0_dout, s_lb1_dout;
  logic        s_win_valid, s_frame_done;
  logic [71:0] s_win_data;

  line_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_W(11), .DATA_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_pixel(s_pix), .in_valid(s_valid), .in_sof(s_sof),
    .lb0_addr(s_lb0_addr), .lb0_we(s_lb0_we), .lb0_din(s_lb0_din), .lb0_dout(s_lb0_dout),
    .lb1_addr(s_lb1_addr), .lb1_we(s_lb1_we), .lb1_din(s_lb1_din), .lb1_dout(s_lb1_dout),
    .win_valid(s_win_valid), .win_data(s_win_data), .frame_done(s_frame_done)
  );

  // Large instance (default width)
  logic [7:0]  l_pix;
  logic        l_valid, l_sof;
  logic [10:0] l_lb0_addr, l_lb1_addr;
  logic        l_lb0_we, l_lb1_we;
  logic [7:0]  l_lb0_din, l_lb1_din, l_lb0_dout, l_lb1_dout;
  logic        l_win_valid, l_frame_done;
  logic [71:0] l_win_data;

  line_window_gen #(.IMG_WIDTH(1600), .IMG_HEIGHT(1200), .ADDR_W(11), .DATA_W(8)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .in_pixel(l_pix), .in_valid(l_valid), .in_sof(l_sof),
    .lb0_addr(l_lb0_addr), .lb0_we(l_lb0_we), .lb0_din(l_lb0_din), .lb0_dout(l_lb0_dout),
    .lb1_addr(l_lb1_addr), .lb1_we(l_lb1_we), .lb1_din(l_lb1_din), .lb1_dout(l_lb1_dout),
    .win_valid(l_win_valid), .win_data(l_win_data), .frame_done(l_frame_done)
  );

  // Line buffer RAMs: registered read returning the pre-write content
  logic [7:0] s_ram0 [2048];
  logic [7:0] s_ram1 [2048];
  logic [7:0] l_ram0 [2048];
  logic [7:0] l_ram1 [2048];

  always @(posedge clk) begin
    if (s_lb0_we) s_ram0[s_lb0_addr] <= s_lb0_din;
    s_lb0_dout <= s_ram0[s_lb0_addr];
    if (s_lb1_we) s_ram1[s_lb1_addr] <= s_lb1_din;
    s_lb1_dout <= s_ram1[s_lb1_addr];
    if (l_lb0_we) l_ram0[l_lb0_addr] <= l_lb0_din;
    l_lb0_dout <= l_ram0[l_lb0_addr];
    if (l_lb1_we) l_ram1[l_lb1_addr] <= l_lb1_din;
    l_lb1_dout <= l_ram1[l_lb1_addr];
  end

  // Window capture, sampled on the falling edge
  logic [72:0] sq [$];
  logic [71:0] lq [$];

  always @(negedge clk) begin
    if (s_win_valid) sq.push_back({s_frame_done, s_win_data});
    if (l_win_valid) lq.push_back(l_win_data);
  end

  logic [7:0] img [4][1600];

  task automatic s_px(input logic [7:0] p, input logic sof);
    s_pix = p; s_valid = 1'b1; s_sof = sof;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic s_idle(input int n);
    s_valid = 1'b0; s_sof = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [7:0] pv(input int base, input int r, input int c);
    return 8'(base + 16 * r + c);
  endfunction

  // Four windows of a 4x4 frame, in raster order of the pixel that completes them
  task automatic compare_small(input string tag, input int base);
    logic [72:0] e;
    int r, c;
    check($sformatf("%s_count", tag), 80'(sq.size()), 80'd4);
    for (int k = 0; k < 4 && k < sq.size(); k++) begin
      r = 2 + k / 2;
      c = 2 + k % 2;
      e = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e[8*(3*i+j) +: 8] = pv(base, r - 2 + i, c - 2 + j);
      e[72] = (r == 3 && c == 3);
      check($sformatf("%s_win%0d", tag, k), 80'(sq[k]), 80'(e));
    end
  endtask

  initial begin
    int pat [5] = '{1, 0, 1, 1, 0};
    int k;
    logic [71:0] e;

    s_pix = '0; s_valid = 1'b0; s_sof = 1'b0;
    l_pix = '0; l_valid = 1'b0; l_sof = 1'b0;

    // Reset state
    #2;
    s_valid = 1'b1;
    #1;
    check("rst_lb0_we", 80'(s_lb0_we), 80'd0);
    check("rst_win_valid", 80'(s_win_valid), 80'd0);
    check("rst_frame_done", 80'(s_frame_done), 80'd0);
    check("rst_lb1_we", 80'(s_lb1_we), 80'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous 4x4 frame with latency and line-wrap spot checks
    sq.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s_px(pv(0, r, c), (r == 0 && c == 0));
        if (r == 2 && c == 3) check("lat_not_yet", 80'(s_win_valid), 80'd0);
        if (r == 3 && c == 0) begin
          check("lat_first_valid", 80'(s_win_valid), 80'd1);
          check("first_win_data", 80'(s_win_data), 80'h22_21_20_12_11_10_02_01_00);
        end
        if (r == 3 && c == 2) check("wrap_px30", 80'(s_win_valid), 80'd0);
        if (r == 3 && c == 3) check("wrap_px31", 80'(s_win_valid), 80'd0);
      end
    end
    s_idle(1);
    check("wrap_next_valid", 80'(s_win_valid), 80'd1);
    check("wrap_next_centre", 80'(s_win_data[39:32]), 80'h21);
    check("wrap_next_done", 80'(s_frame_done), 80'd0);
    s_idle(1);
    check("last_done", 80'(s_frame_done), 80'd1);
    check("last_p22", 80'(s_win_data[71:64]), 80'h33);
    s_idle(4);
    compare_small("cont", 0);

    // Same frame with in_valid toggling 1,0,1,1,0
    sq.delete();
    k = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        while (pat[k % 5] == 0) begin
          s_idle(1);
          k++;
        end
        s_px(pv(0, r, c), (r == 0 && c == 0));
        k++;
      end
    end
    s_idle(6);
    compare_small("bubble", 0);

    // Mid-frame in_sof at (2,1) restarts the raster
    sq.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        s_px(pv(8'h40, r, c), 1'b0);
    s_px(pv(8'h40, 2, 0), 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s_px(pv(8'h80, r, c), (r == 0 && c == 0));
    s_idle(6);
    compare_small("midsof", 8'h80);

    // Reset asserted mid-stream while a window is being presented
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        s_px(pv(0, r, c), (r == 0 && c == 0));
    s_px(pv(0, 3, 0), 1'b0);
    check("pre_rst_valid", 80'(s_win_valid), 80'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_win_valid", 80'(s_win_valid), 80'd0);
    check("midrst_lb1_we", 80'(s_lb1_we), 80'd0);
    check("midrst_frame_done", 80'(s_frame_done), 80'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sq.delete();
    s_pix = pv(8'hC0, 0, 0); s_valid = 1'b1; s_sof = 1'b0;
    #1;
    check("post_rst_addr", 80'(s_lb0_addr), 80'd0);
    check("post_rst_we", 80'(s_lb0_we), 80'd1);
    @(posedge clk); #1;
    for (int p = 1; p < 16; p++)
      s_px(pv(8'hC0, p / 4, p % 4), 1'b0);
    s_idle(6);
    compare_small("postrst", 8'hC0);

    // 1600-wide random image against a 3x3 reference
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 1600; c++)
        img[r][c] = 8'($urandom_range(0, 255));
    lq.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 1600; c++) begin
        l_pix = img[r][c]; l_valid = 1'b1; l_sof = (r == 0 && c == 0);
        #1;
        if (c == 0 || c == 1 || c == 1599)
          check($sformatf("l_addr_r%0d_c%0d", r, c), 80'(l_lb0_addr), 80'(c));
        @(posedge clk); #1;
      end
    end
    l_valid = 1'b0; l_sof = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("l_count", 80'(lq.size()), 80'd3196);
    for (int w = 0; w < 3196 && w < lq.size(); w++) begin
      int r, c;
      r = 2 + w / 1598;
      c = 2 + w % 1598;
      e = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
      check($sformatf("l_win_r%0d_c%0d", r, c), 80'(lq[w]), 80'(e));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Writer/reader controller for two external line_buffer RAMs (8-bit data, 11-bit address, 1-cycle registered read, read-before-write on the same address).
- Accepts a raster pixel stream and cascades rows through the two RAMs. Emits a registered 3x3 neighbourhood window per interior pixel to the downstream convolution/filter stages.
- Sits between the pixel source and the 3x3 kernel blocks.

Parameters:
- IMG_WIDTH, 1600, pixels per line; 3..1600.
- IMG_HEIGHT, 1200, lines per frame; >= 3.
- ADDR_W, 11, line buffer address width.
- DATA_W, 8, pixel width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_pixel  in  DATA_W  input pixel.
- in_valid  in  1  pixel accepted on each clk edge where high; no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0).
- lb0_addr  out  ADDR_W  line buffer 0 address.
- lb0_we  out  1  line buffer 0 write enable.
- lb0_din  out  DATA_W  line buffer 0 write data.
- lb0_dout  in  DATA_W  line buffer 0 registered read data.
- lb1_addr  out  ADDR_W  line buffer 1 address.
- lb1_we  out  1  line buffer 1 write enable.
- lb1_din  out  DATA_W  line buffer 1 write data.
- lb1_dout  in  DATA_W  line buffer 1 registered read data.
- win_valid  out  1  win_data holds a valid window.
- win_data  out  9*DATA_W  window; p[i][j] at bits [DATA_W*(3i+j) +: DATA_W]; i=0 top row, j=0 oldest/leftmost column.
- frame_done  out  1  one-cycle pulse at the window of the frame's last pixel.

Behaviour:
- Reset (async assert, sync release): col/row counters 0; pipeline valids 0; window regs 0; win_valid, frame_done, lb1_we all 0. lb0_we = in_valid & rst_n.
- Counters:
  - col increments per accepted pixel.
  - At IMG_WIDTH-1: col -> 0, row++.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1): row -> 0.
  - in_sof & in_valid forces the current pixel to (0,0); counters advance from there.
- Stage 0 (combinational): lb0_addr = current col (or 0 when in_sof & in_valid), lb0_din = in_pixel, lb0_we = in_valid. Edge t: RAM writes the pixel and returns the old content (row-1).
- Stage 1 regs (edge t): pixel_d1, col_d1, row_d1, valid_d1.
  - lb1_addr = col_d1, lb1_din = lb0_dout, lb1_we = valid_d1.
  - Edge t+1: lb1 stores row-1 and returns row-2.
- Stage 2 regs (edge t+1), loaded only when valid_d1: bot = pixel_d1, mid = lb0_dout, col/row_d2. valid_d2 <= valid_d1.
- lb*_dout is sampled only in the cycle following that RAM's write. Idle cycles re-read the just-written value, which must be ignored.
- Stage 3 (edge t+2), only when valid_d2:
  - Window columns shift left; new column j=2 = {top = lb1_dout, mid, bot}.
  - win_valid <= valid_d2 & row_d2 >= 2 & col_d2 >= 2; otherwise win_valid <= 0 on every edge.
- Latency: window centred on (r-1, c-1) is presented 3 edges after pixel (r,c) is sampled.
- No padding. Border pixels produce no window. Windows never straddle lines.
- Rows 0-1 read uninitialised RAM; win_valid masks this.
- Bubbles: in_valid may drop any cycle; the pipeline advances only per valid pixel. Output sequence is identical to gap-free input.
- frame_done: asserted with win_valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset mid-frame: all state cleared. RAM contents are not cleared and are masked by the row >= 2 rule.
- Throughput: one pixel per clock sustained.

Test Plan:
- Reset: pulse rst_n low mid-stream -> win_valid=0, lb1_we=0, frame_done=0 immediately. First pixel after release drives lb0_addr=0, lb0_we=1.
- Small frame (IMG_WIDTH=4, IMG_HEIGHT=4), continuous, pixel=16*row+col, in_sof on first:
  - First win_valid 3 edges after pixel (2,2) sampled.
  - win_data p00..p22 = 00,01,02,10,11,12,20,21,22.
  - Exactly 4 windows per frame; frame_done with the window ending at 0x33.
- Same frame, in_valid toggling 1,0,1,1,0: window values and order identical to the continuous case; win_valid never high on a cycle without a new window.
- Line wrap: after pixel (2,3), pixels (3,0) and (3,1) produce no window. Next window is centred (2,1) = 21 after pixel (3,2).
- Mid-frame in_sof at (2,1): counters resync to (0,0); no win_valid until the new row 2, col 2.
- Default IMG_WIDTH=1600: lb0_addr counts 0..1599 then wraps to 0. Window values match a golden 3x3 model over a 1600x4 random image.
